huffman_pack: RTL and testbench
===============================

HUFFMAN_PACK -- requirements
Module: huffman_pack

Interface
REQ-001 SHALL have parameter PAD_BIT, default 1'b0: the bit value used to fill the final partial byte of a message.
REQ-002 SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- code_valid  in  1  code table present on HC*/M*.
- HC1..HC6  in  8 each  code for symbol k, right-aligned.
- M1..M6  in  8 each  code mask for symbol k, contiguous ones from the LSB; code length = number of ones (0..8).
- sym_valid  in  1  symbol offered.
- sym_data  in  8  symbol value; legal values are 1..6.
- sym_last  in  1  offered symbol is the last of its message.
- sym_ready  out  1  block can accept a symbol.
- out_valid  out  1  packed byte available.
- out_data  out  8  packed byte; first-emitted bit is in bit 7.
- out_last  out  1  byte is the final byte of its message.
- out_ready  in  1  downstream accepts the byte.
- err  out  1  sticky flag: an illegal symbol was seen.
- total_bits  out  16  code bits packed in the current message; saturates at 16'hFFFF.
REQ-003 The clock SHALL be the only clock, and reset SHALL be asynchronous and active-low.

Function
REQ-004 The state machine SHALL have the states IDLE, RUN, FLUSH and DONE.
REQ-005 In IDLE, code_valid=1 SHALL capture, in that cycle, len_k = popcount(M_k) and code_k = HC_k & M_k for k = 1..6, then move to RUN.
REQ-006 code_valid SHALL be ignored in every state other than IDLE.
REQ-007 Bits SHALL be held in a 16-bit left-justified accumulator with a fill count of 0..16.
REQ-008 sym_ready SHALL be 1 only in RUN and only when fill <= 8.
REQ-009 A symbol SHALL transfer on sym_valid && sym_ready.
REQ-010 On a symbol transfer, code_k SHALL be appended MSB-first, and fill and total_bits SHALL each increase by len_k.
REQ-011 An illegal symbol (value not 1..6, or len_k = 0) SHALL be consumed, append no bits, and set err.
- err stays 1 until reset.
REQ-012 out_valid SHALL be 1 whenever fill >= 8, with out_data equal to the top 8 accumulator bits.
REQ-013 A byte SHALL transfer on out_valid && out_ready.
- On transfer, the accumulator shifts left by 8 and fill decreases by 8.
REQ-014 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-015 A symbol transfer and a byte transfer in the same cycle SHALL both take effect: fill_next = fill - 8 + len_k.
REQ-016 Latency: a symbol accepted in cycle N that brings fill to >= 8 SHALL produce out_valid=1 in cycle N+1.
REQ-017 A transfer with sym_last=1 SHALL move the block to FLUSH, where sym_ready=0.
REQ-018 FLUSH SHALL emit all remaining full bytes, then one more byte only if 0 < fill < 8.
- That partial byte is the remaining bits, left-justified and padded with PAD_BIT.
REQ-019 out_last SHALL be 1 on the final byte emitted in FLUSH.
REQ-020 If a message ends with zero bits packed in total, FLUSH SHALL emit one byte of eight PAD_BIT values with out_last=1.
REQ-021 After the out_last byte transfers, the block SHALL go to DONE for one cycle, then to RUN.
- The table is retained.
- fill and total_bits are cleared on the DONE->RUN transition.
- err is retained.
REQ-022 sym_valid SHALL have no effect in IDLE, FLUSH and DONE.

Reset
REQ-023 While reset=0, the outputs SHALL be: sym_ready=0, out_valid=0, out_data=8'h00, out_last=0, err=0, total_bits=0.
- Also: state=IDLE, fill=0, accumulator=0, and the table is marked invalid.
REQ-024 An assertion of reset in any state, including mid-message or mid-backpressure, SHALL discard all buffered bits.
- A new table load is required after reset.

Verification
Table used: HC/M = 1:00/01, 2:02/03, 3:06/07, 4:0E/0F, 5:1E/1F, 6:1F/1F.
REQ-025 Symbols 1,2,3,4 (last on 4) with out_ready=1 -> byte 8'h5B, then byte 8'h80 with out_last=1; total_bits=10.
REQ-026 Eight symbol-1 inputs, last on the 8th -> a single byte 8'h00 with out_last=1; no pad byte; total_bits=8.
REQ-027 Symbol 7, then symbol 6 with last -> err=1; single byte 8'hF8 with out_last=1; total_bits=5.
REQ-028 Symbols 6,6,6,6 with out_ready=0 -> out_valid=1 with out_data=8'hFF held; sym_ready=0 once fill > 8.
- Then out_ready=1 -> the byte sequence resumes with no bits lost.
REQ-029 Drive reset=0 mid-message with fill=13 -> all outputs return to their reset values at once.
- A following sym_valid is not accepted until code_valid reloads the table.
REQ-030 Pulse code_valid with a different table while in RUN -> the table is unchanged; REQ-025 output is reproduced.

Source files
------------

// File: rtl/huffman_pack.sv
// +-----------------------------------------------------------------------------+
// | Module   : huffman_pack                                                     |
// | Function : packs variable-length codes for symbols 1..6 into MSB-first      |
// |            bytes, with per-message flush, padding and last-byte marking.    |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module huffman_pack #(
  parameter logic PAD_BIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [7:0]  HC1,
  input  logic [7:0]  HC2,
  input  logic [7:0]  HC3,
  input  logic [7:0]  HC4,
  input  logic [7:0]  HC5,
  input  logic [7:0]  HC6,
  input  logic [7:0]  M1,
  input  logic [7:0]  M2,
  input  logic [7:0]  M3,
  input  logic [7:0]  M4,
  input  logic [7:0]  M5,
  input  logic [7:0]  M6,
  input  logic        sym_valid,
  input  logic [7:0]  sym_data,
  input  logic        sym_last,
  output logic        sym_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        err,
  output logic [15:0] total_bits
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          C_NSYM    = 6;
  localparam logic [4:0]  C_BYTE    = 5'd8;
  localparam logic [15:0] C_SAT_MAX = 16'hFFFF;

  state_t      r_state;
  state_t      w_state_next;

  logic [15:0] r_acc;
  logic [4:0]  r_fill;
  logic [15:0] r_total;
  logic        r_err;
  logic        r_tbl_valid;
  logic [7:0]  r_code [C_NSYM];
  logic [3:0]  r_len  [C_NSYM];

  logic [7:0]  w_hc [C_NSYM];
  logic [7:0]  w_m  [C_NSYM];

  logic [7:0]  w_sel_code;
  logic [3:0]  w_sel_len;
  logic        w_in_range;
  logic        w_legal;
  logic [7:0]  w_app_code;
  logic [3:0]  w_app_len;
  logic [15:0] w_code_lj;

  logic        w_sym_xfer;
  logic        w_out_xfer;
  logic [4:0]  w_fill_base;
  logic [15:0] w_acc_base;
  logic [15:0] w_acc_app;
  logic [4:0]  w_fill_app;
  logic [16:0] w_total_sum;
  logic [15:0] w_total_sat;
  logic [7:0]  w_keep;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  assign w_hc[0] = HC1;
  assign w_hc[1] = HC2;
  assign w_hc[2] = HC3;
  assign w_hc[3] = HC4;
  assign w_hc[4] = HC5;
  assign w_hc[5] = HC6;
  assign w_m[0]  = M1;
  assign w_m[1]  = M2;
  assign w_m[2]  = M3;
  assign w_m[3]  = M4;
  assign w_m[4]  = M5;
  assign w_m[5]  = M6;

  // Table lookup through a case so out-of-range symbol values never index the arrays
  always_comb begin
    w_sel_code = 8'h00;
    w_sel_len  = 4'd0;
    w_in_range = 1'b1;
    case (sym_data)
      8'd1: begin w_sel_code = r_code[0]; w_sel_len = r_len[0]; end
      8'd2: begin w_sel_code = r_code[1]; w_sel_len = r_len[1]; end
      8'd3: begin w_sel_code = r_code[2]; w_sel_len = r_len[2]; end
      8'd4: begin w_sel_code = r_code[3]; w_sel_len = r_len[3]; end
      8'd5: begin w_sel_code = r_code[4]; w_sel_len = r_len[4]; end
      8'd6: begin w_sel_code = r_code[5]; w_sel_len = r_len[5]; end
      default: w_in_range = 1'b0;
    endcase
  end

  assign w_legal    = w_in_range && (w_sel_len != 4'd0);
  assign w_app_code = w_legal ? w_sel_code : 8'h00;
  assign w_app_len  = w_legal ? w_sel_len  : 4'd0;
  assign w_code_lj  = {w_app_code, 8'h00} << (4'd8 - w_app_len);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    sym_ready    = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    case (r_state)
      IDLE: begin
        if (code_valid) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        sym_ready = r_tbl_valid && (r_fill <= C_BYTE);
        out_valid = (r_fill >= C_BYTE);
        if (sym_valid && sym_ready && sym_last) begin
          w_state_next = FLUSH;
        end
      end
      FLUSH: begin
        // With fill==0 the emitted byte is pure padding, so FLUSH always has one final byte
        out_valid = 1'b1;
        out_last  = (r_fill <= C_BYTE);
        if (out_ready && out_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = RUN;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_keep   = (r_fill >= C_BYTE) ? 8'hFF : ~(8'hFF >> r_fill[3:0]);
  assign out_data = (r_state == FLUSH)
                  ? ((r_acc[15:8] & w_keep) | ({8{PAD_BIT}} & ~w_keep))
                  : r_acc[15:8];

  assign w_sym_xfer  = sym_valid && sym_ready;
  assign w_out_xfer  = out_valid && out_ready;
  assign w_fill_base = w_out_xfer ? (r_fill - C_BYTE) : r_fill;
  assign w_acc_base  = w_out_xfer ? {r_acc[7:0], 8'h00} : r_acc;
  assign w_acc_app   = w_acc_base | (w_code_lj >> w_fill_base);
  assign w_fill_app  = w_fill_base + {1'b0, w_app_len};
  assign w_total_sum = {1'b0, r_total} + {13'd0, w_app_len};
  assign w_total_sat = w_total_sum[16] ? C_SAT_MAX : w_total_sum[15:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc       <= 16'h0000;
      r_fill      <= 5'd0;
      r_total     <= 16'h0000;
      r_err       <= 1'b0;
      r_tbl_valid <= 1'b0;
      for (int i = 0; i < C_NSYM; i++) begin
        r_code[i] <= 8'h00;
        r_len[i]  <= 4'd0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (code_valid) begin
            r_tbl_valid <= 1'b1;
            for (int i = 0; i < C_NSYM; i++) begin
              r_code[i] <= w_hc[i] & w_m[i];
              r_len[i]  <= popcount8(w_m[i]);
            end
          end
        end
        RUN: begin
          if (w_sym_xfer) begin
            r_acc   <= w_acc_app;
            r_fill  <= w_fill_app;
            r_total <= w_total_sat;
            if (!w_legal) begin
              r_err <= 1'b1;
            end
          end else if (w_out_xfer) begin
            r_acc  <= w_acc_base;
            r_fill <= w_fill_base;
          end
        end
        FLUSH: begin
          if (w_out_xfer) begin
            if (out_last) begin
              r_acc  <= 16'h0000;
              r_fill <= 5'd0;
            end else begin
              r_acc  <= w_acc_base;
              r_fill <= w_fill_base;
            end
          end
        end
        DONE: begin
          r_acc   <= 16'h0000;
          r_fill  <= 5'd0;
          r_total <= 16'h0000;
        end
        default: begin
          r_acc  <= 16'h0000;
          r_fill <= 5'd0;
        end
      endcase
    end
  end

  assign err        = r_err;
  assign total_bits = r_total;

endmodule

`default_nettype wire

// File: tb/tb_huffman_pack.sv
// +-----------------------------------------------------------------------------+
// | Module   : tb_huffman_pack                                                  |
// | Function : directed self-checking bench for huffman_pack.                   |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_huffman_pack;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        code_valid = 1'b0;
  logic [7:0]  HC1 = 8'h00, HC2 = 8'h00, HC3 = 8'h00, HC4 = 8'h00, HC5 = 8'h00, HC6 = 8'h00;
  logic [7:0]  M1 = 8'h00, M2 = 8'h00, M3 = 8'h00, M4 = 8'h00, M5 = 8'h00, M6 = 8'h00;
  logic        sym_valid = 1'b0;
  logic [7:0]  sym_data = 8'h00;
  logic        sym_last = 1'b0;
  logic        sym_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        err;
  logic [15:0] total_bits;

  int          n_total = 0;
  int          n_bad = 0;
  logic [8:0]  log_mem [0:63];
  int          byte_cnt = 0;
  int          done_cnt = 0;
  int          d_exp = 0;
  int          base = 0;
  logic [15:0] last_total = 16'h0000;

  always #5 clk = ~clk;

  huffman_pack #(.PAD_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last), .sym_ready(sym_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .err(err), .total_bits(total_bits)
  );

  // Byte logger: a transfer is sampled mid-cycle, ahead of the edge that commits it
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (byte_cnt < 64) log_mem[byte_cnt] = {out_last, out_data};
      byte_cnt = byte_cnt + 1;
      if (out_last) begin
        last_total = total_bits;
        done_cnt   = done_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_std_table();
    HC1 = 8'h00; M1 = 8'h01;
    HC2 = 8'h02; M2 = 8'h03;
    HC3 = 8'h06; M3 = 8'h07;
    HC4 = 8'h0E; M4 = 8'h0F;
    HC5 = 8'h1E; M5 = 8'h1F;
    HC6 = 8'h1F; M6 = 8'h1F;
  endtask

  task automatic set_alt_table();
    HC1 = 8'hFF; M1 = 8'hFF;
    HC2 = 8'hFF; M2 = 8'hFF;
    HC3 = 8'hFF; M3 = 8'hFF;
    HC4 = 8'hFF; M4 = 8'hFF;
    HC5 = 8'hFF; M5 = 8'hFF;
    HC6 = 8'hFF; M6 = 8'hFF;
  endtask

  task automatic pulse_code_valid();
    code_valid = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int  n;
    logic got;
    n = 0; got = 1'b0;
    sym_valid = 1'b1; sym_data = d; sym_last = last;
    while (!got && n < 50) begin
      @(negedge clk);
      got = sym_ready;
      @(posedge clk); #1;
      n++;
    end
    sym_valid = 1'b0; sym_last = 1'b0; sym_data = 8'h00;
    chk("sym_accept", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_msg();
    int n;
    n = 0;
    d_exp++;
    while (done_cnt < d_exp && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("msg_timeout", done_cnt, d_exp);
  endtask

  task automatic check_msg(input string tag, input int nexp,
                           input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2,
                           input logic [15:0] tot);
    chk({tag, "_nbytes"}, byte_cnt - base, nexp);
    if (nexp > 0) chk({tag, "_b0"}, {23'd0, log_mem[base]}, {23'd0, e0});
    if (nexp > 1) chk({tag, "_b1"}, {23'd0, log_mem[base + 1]}, {23'd0, e1});
    if (nexp > 2) chk({tag, "_b2"}, {23'd0, log_mem[base + 2]}, {23'd0, e2});
    chk({tag, "_total"}, {16'd0, last_total}, {16'd0, tot});
    // One cycle of DONE, then RUN with counters cleared
    chk({tag, "_done_ready"}, {31'd0, sym_ready}, 32'd0);
    chk({tag, "_done_total"}, {16'd0, total_bits}, {16'd0, tot});
    @(posedge clk); #1;
    chk({tag, "_run_ready"}, {31'd0, sym_ready}, 32'd1);
    chk({tag, "_run_total"}, {16'd0, total_bits}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sym_ready"}, {31'd0, sym_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
    chk({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_total"}, {16'd0, total_bits}, 32'd0);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_table_ready", {31'd0, sym_ready}, 32'd0);

    set_std_table();
    pulse_code_valid();
    chk("loaded_ready", {31'd0, sym_ready}, 32'd1);

    // Symbols 1,2,3,4 -> 5B, 80(last), 10 bits
    out_ready = 1'b1;
    base = byte_cnt;
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b1);
    wait_msg();
    check_msg("m1234", 2, {1'b0, 8'h5B}, {1'b1, 8'h80}, 9'h000, 16'd10);
    chk("m1234_err", {31'd0, err}, 32'd0);

    // Eight symbol-1 -> single 00(last), no pad byte
    base = byte_cnt;
    for (int i = 0; i < 8; i++) send(8'd1, (i == 7));
    wait_msg();
    check_msg("m8x1", 1, {1'b1, 8'h00}, 9'h000, 9'h000, 16'd8);

    // Illegal 7, then 6(last) -> err, F8(last), 5 bits
    base = byte_cnt;
    send(8'd7, 1'b0);
    chk("illegal_err", {31'd0, err}, 32'd1);
    chk("illegal_total", {16'd0, total_bits}, 32'd0);
    send(8'd6, 1'b1);
    wait_msg();
    check_msg("m76", 1, {1'b1, 8'hF8}, 9'h000, 9'h000, 16'd5);

    // Backpressure: two 6s fill to 10, byte FF held, input stalled
    out_ready = 1'b0;
    base = byte_cnt;
    send(8'd6, 1'b0); send(8'd6, 1'b0);
    chk("bp_ready", {31'd0, sym_ready}, 32'd0);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_data", {24'd0, out_data}, 32'hFF);
    chk("bp_last", {31'd0, out_last}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_data", {24'd0, out_data}, 32'hFF);
    out_ready = 1'b1;
    send(8'd6, 1'b0); send(8'd6, 1'b1);
    wait_msg();
    check_msg("m6666", 3, {1'b0, 8'hFF}, {1'b0, 8'hFF}, {1'b1, 8'hF0}, 16'd20);
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Reload attempt in RUN is ignored
    set_alt_table();
    pulse_code_valid();
    set_std_table();
    base = byte_cnt;
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b1);
    wait_msg();
    check_msg("reload", 2, {1'b0, 8'h5B}, {1'b1, 8'h80}, 9'h000, 16'd10);

    // Mid-message reset with fill=13
    out_ready = 1'b0;
    send(8'd4, 1'b0); send(8'd4, 1'b0); send(8'd5, 1'b0);
    chk("f13_valid", {31'd0, out_valid}, 32'd1);
    chk("f13_data", {24'd0, out_data}, 32'hEE);
    chk("f13_total", {16'd0, total_bits}, 32'd13);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    reset = 1'b1;
    base = byte_cnt;
    sym_valid = 1'b1; sym_data = 8'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("postrst_ready", {31'd0, sym_ready}, 32'd0);
    chk("postrst_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    sym_valid = 1'b0;
    chk("postrst_total", {16'd0, total_bits}, 32'd0);
    pulse_code_valid();
    out_ready = 1'b1;
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b1);
    wait_msg();
    check_msg("postrst", 2, {1'b0, 8'h5B}, {1'b1, 8'h80}, 9'h000, 16'd10);
    chk("postrst_err", {31'd0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
